// File: rtl/mem_pkg.sv
// Shared types and widths for the LEGv8 memory-access stage.
package mem_pkg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned RIDX_W     = 5;
    localparam int unsigned ALIGN_BITS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [RIDX_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              fault;
    } wb_rec_t;

endpackage

// File: rtl/mem_access_if.sv
// Execute-side, data-memory and writeback signals of the memory-access stage.
interface mem_access_if;

    logic                              ex_valid;
    logic                              ex_ready;
    logic [mem_pkg::DATA_W-1:0]        alu_result;
    logic [mem_pkg::DATA_W-1:0]        write_data;
    logic                              mem_read;
    logic                              mem_write;
    logic                              reg_write;
    logic [mem_pkg::RIDX_W-1:0]        rd;

    logic                              dm_req;
    logic                              dm_we;
    logic [mem_pkg::DATA_W-1:0]        dm_addr;
    logic [mem_pkg::DATA_W-1:0]        dm_wdata;
    logic                              dm_gnt;
    logic                              dm_rvalid;
    logic [mem_pkg::DATA_W-1:0]        dm_rdata;

    logic                              wb_valid;
    logic                              wb_reg_write;
    logic [mem_pkg::RIDX_W-1:0]        wb_rd;
    logic [mem_pkg::DATA_W-1:0]        wb_data;
    logic                              fault;

    // Stage side: master of the data-memory request bus
    modport master (
        input  ex_valid, alu_result, write_data, mem_read, mem_write, reg_write, rd,
        input  dm_gnt, dm_rvalid, dm_rdata,
        output ex_ready, dm_req, dm_we, dm_addr, dm_wdata,
        output wb_valid, wb_reg_write, wb_rd, wb_data, fault
    );

    // Environment side: execute stage, data memory and writeback consumer
    modport slave (
        output ex_valid, alu_result, write_data, mem_read, mem_write, reg_write, rd,
        output dm_gnt, dm_rvalid, dm_rdata,
        input  ex_ready, dm_req, dm_we, dm_addr, dm_wdata,
        input  wb_valid, wb_reg_write, wb_rd, wb_data, fault
    );

endinterface

// File: rtl/mem_access_align_check.sv
// Flags operations that must not reach memory: load+store together or a misaligned doubleword address.
module align_check
    import mem_pkg::*;
(
    input  logic [ALIGN_BITS-1:0] addr_lsb,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  fault_c
);

    // Illegal combination or nonzero low address bits on a memory op
    always_comb begin
        fault_c = (mem_read && mem_write) ||
                  ((mem_read || mem_write) && (addr_lsb != '0));
    end

endmodule

// File: rtl/mem_access.sv
// LEGv8 memory-access stage: request/grant/response to data memory, one writeback record per operation.
module mem_access
    import mem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mem_access_if.master bus
);

    mem_state_t        state_q, state_d;
    logic              ex_ready_q, ex_ready_d;
    logic              dm_req_q, dm_req_d;
    logic              dm_we_q, dm_we_d;
    logic [DATA_W-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
    logic [RIDX_W-1:0] rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    wb_rec_t           wb_q, wb_d;
    logic              align_fault_c;

    align_check u_align_check (
        .addr_lsb  (bus.alu_result[ALIGN_BITS-1:0]),
        .mem_read  (bus.mem_read),
        .mem_write (bus.mem_write),
        .fault_c   (align_fault_c)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        dm_we_d       = dm_we_q;
        dm_addr_d     = dm_addr_q;
        dm_wdata_d    = dm_wdata_q;
        rd_d          = rd_q;
        reg_write_d   = reg_write_q;
        wb_d          = wb_q;
        wb_d.valid    = 1'b0;
        wb_d.fault    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.ex_valid) begin
                    if (align_fault_c) begin
                        wb_d.valid     = 1'b1;
                        wb_d.fault     = 1'b1;
                        wb_d.reg_write = 1'b0;
                    end else if (!bus.mem_read && !bus.mem_write) begin
                        wb_d.valid     = 1'b1;
                        wb_d.data      = bus.alu_result;
                        wb_d.rd        = bus.rd;
                        wb_d.reg_write = bus.reg_write;
                    end else begin
                        dm_addr_d   = bus.alu_result;
                        dm_we_d     = bus.mem_write;
                        dm_wdata_d  = bus.mem_write ? bus.write_data : '0;
                        rd_d        = bus.rd;
                        reg_write_d = bus.reg_write;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.dm_gnt) begin
                    dm_we_d = 1'b0;
                    if (dm_we_q) begin
                        wb_d.valid     = 1'b1;
                        wb_d.reg_write = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.dm_rvalid) begin
                    wb_d.valid     = 1'b1;
                    wb_d.data      = bus.dm_rdata;
                    wb_d.rd        = rd_q;
                    wb_d.reg_write = reg_write_q;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dm_req_d   = (state_d == REQ);
        ex_ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ex_ready_q  <= 1'b1;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_q        <= '0;
        end else begin
            state_q     <= state_d;
            ex_ready_q  <= ex_ready_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            wb_q        <= wb_d;
        end
    end

    assign bus.ex_ready     = ex_ready_q;
    assign bus.dm_req       = dm_req_q;
    assign bus.dm_we        = dm_we_q;
    assign bus.dm_addr      = dm_addr_q;
    assign bus.dm_wdata     = dm_wdata_q;
    assign bus.wb_valid     = wb_q.valid;
    assign bus.wb_reg_write = wb_q.reg_write;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.wb_data      = wb_q.data;
    assign bus.fault        = wb_q.fault;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: transaction-level reference model checked every cycle plus directed literal checks.
module tb_mem_access;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   wb_count = 0;

    always #5 clk = ~clk;

    mem_access_if bus ();

    mem_access dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One outstanding memory transaction at most; the stage is ready exactly when none is outstanding.
    logic        m_live = 1'b0;
    logic        m_pend, m_granted, m_is_load;
    logic [63:0] m_addr, m_wdata;
    logic [4:0]  m_rd;
    logic        m_rw;
    logic        e_wb_valid, e_fault, e_rw, e_chk_data;
    logic [63:0] e_data;
    logic [4:0]  e_rd;

    always @(posedge clk) begin
        logic bad;
        if (!reset) begin
            m_live     = 1'b1;
            m_pend     = 1'b0;
            m_granted  = 1'b0;
            m_is_load  = 1'b0;
            m_addr     = '0;
            m_wdata    = '0;
            m_rd       = '0;
            m_rw       = 1'b0;
            e_wb_valid = 1'b0;
            e_fault    = 1'b0;
            e_rw       = 1'b0;
            e_chk_data = 1'b0;
            e_data     = '0;
            e_rd       = '0;
        end else if (m_live) begin
            e_wb_valid = 1'b0;
            e_fault    = 1'b0;
            e_chk_data = 1'b0;
            if (!m_pend && bus.ex_valid) begin
                bad = (bus.mem_read && bus.mem_write) ||
                      ((bus.mem_read || bus.mem_write) && (bus.alu_result % 8 != 0));
                if (bad) begin
                    e_wb_valid = 1'b1;
                    e_fault    = 1'b1;
                    e_rw       = 1'b0;
                end else if (!bus.mem_read && !bus.mem_write) begin
                    e_wb_valid = 1'b1;
                    e_chk_data = 1'b1;
                    e_data     = bus.alu_result;
                    e_rd       = bus.rd;
                    e_rw       = bus.reg_write;
                end else begin
                    m_pend    = 1'b1;
                    m_granted = 1'b0;
                    m_is_load = bus.mem_read;
                    m_addr    = bus.alu_result;
                    m_wdata   = bus.mem_write ? bus.write_data : 64'd0;
                    m_rd      = bus.rd;
                    m_rw      = bus.reg_write;
                end
            end else if (m_pend && !m_granted && bus.dm_gnt) begin
                if (m_is_load) begin
                    m_granted = 1'b1;
                end else begin
                    m_pend     = 1'b0;
                    e_wb_valid = 1'b1;
                    e_rw       = 1'b0;
                end
            end else if (m_pend && m_granted && bus.dm_rvalid) begin
                m_pend     = 1'b0;
                e_wb_valid = 1'b1;
                e_chk_data = 1'b1;
                e_data     = bus.dm_rdata;
                e_rd       = m_rd;
                e_rw       = m_rw;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (m_live) begin
            cmp("ex_ready", 64'(bus.ex_ready), 64'(!m_pend));
            cmp("dm_req", 64'(bus.dm_req), 64'(m_pend && !m_granted));
            if (m_pend && !m_granted) begin
                cmp("dm_addr", bus.dm_addr, m_addr);
                cmp("dm_we", 64'(bus.dm_we), 64'(!m_is_load));
                cmp("dm_wdata", bus.dm_wdata, m_wdata);
            end
            cmp("wb_valid", 64'(bus.wb_valid), 64'(e_wb_valid));
            cmp("fault", 64'(bus.fault), 64'(e_fault));
            cmp("wb_reg_write", 64'(bus.wb_reg_write), 64'(e_rw));
            if (e_wb_valid && e_chk_data) begin
                cmp("wb_data", bus.wb_data, e_data);
                cmp("wb_rd", 64'(bus.wb_rd), 64'(e_rd));
            end
            if (bus.wb_valid === 1'b1) wb_count++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic mr, input logic mw, input logic rw,
                       input logic [4:0] rd_i, input logic [63:0] alu, input logic [63:0] wd);
        bus.ex_valid   = v;
        bus.mem_read   = mr;
        bus.mem_write  = mw;
        bus.reg_write  = rw;
        bus.rd         = rd_i;
        bus.alu_result = alu;
        bus.write_data = wd;
    endtask

    task automatic idle_in();
        put(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    endtask

    initial begin
        int c0;
        idle_in();
        bus.dm_gnt    = 1'b0;
        bus.dm_rvalid = 1'b0;
        bus.dm_rdata  = '0;

        // Reset for two edges
        tick();
        tick();
        reset = 1'b1;
        cmp("rst_ex_ready", 64'(bus.ex_ready), 64'd1);
        cmp("rst_dm_req", 64'(bus.dm_req), 64'd0);
        cmp("rst_dm_we", 64'(bus.dm_we), 64'd0);
        cmp("rst_dm_addr", bus.dm_addr, 64'd0);
        cmp("rst_dm_wdata", bus.dm_wdata, 64'd0);
        cmp("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        cmp("rst_wb_rw", 64'(bus.wb_reg_write), 64'd0);
        cmp("rst_wb_data", bus.wb_data, 64'd0);
        cmp("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
        cmp("rst_fault", 64'(bus.fault), 64'd0);

        // ALU pass-through
        put(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 64'h2A, 64'h0);
        tick();
        idle_in();
        cmp("alu_wb_valid", 64'(bus.wb_valid), 64'd1);
        cmp("alu_wb_data", bus.wb_data, 64'h2A);
        cmp("alu_wb_rd", 64'(bus.wb_rd), 64'd3);
        cmp("alu_wb_rw", 64'(bus.wb_reg_write), 64'd1);

        // Stray grant/response while idle must be ignored
        bus.dm_gnt    = 1'b1;
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 64'h5555;
        tick();
        bus.dm_gnt    = 1'b0;
        bus.dm_rvalid = 1'b0;
        cmp("stray_wb_valid", 64'(bus.wb_valid), 64'd0);

        // Store with grant delayed three cycles
        put(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 64'h100, 64'hDEAD);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            cmp("st_dm_req", 64'(bus.dm_req), 64'd1);
            cmp("st_dm_addr", bus.dm_addr, 64'h100);
            cmp("st_dm_we", 64'(bus.dm_we), 64'd1);
            cmp("st_dm_wdata", bus.dm_wdata, 64'hDEAD);
            cmp("st_ex_ready", 64'(bus.ex_ready), 64'd0);
            if (i == 2) bus.dm_gnt = 1'b1;
            tick();
        end
        bus.dm_gnt = 1'b0;
        cmp("st_wb_valid", 64'(bus.wb_valid), 64'd1);
        cmp("st_wb_rw", 64'(bus.wb_reg_write), 64'd0);
        cmp("st_ex_ready_done", 64'(bus.ex_ready), 64'd1);
        cmp("st_dm_req_done", 64'(bus.dm_req), 64'd0);

        // Load with immediate grant, response two cycles later
        put(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 64'h108, 64'h0);
        tick();
        idle_in();
        cmp("ld_dm_req", 64'(bus.dm_req), 64'd1);
        cmp("ld_dm_we", 64'(bus.dm_we), 64'd0);
        cmp("ld_dm_addr", bus.dm_addr, 64'h108);
        cmp("ld_dm_wdata", bus.dm_wdata, 64'd0);
        bus.dm_gnt = 1'b1;
        tick();
        bus.dm_gnt = 1'b0;
        cmp("ld_wait_req", 64'(bus.dm_req), 64'd0);
        cmp("ld_wait_ready", 64'(bus.ex_ready), 64'd0);
        tick();
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 64'hBEEF;
        tick();
        bus.dm_rvalid = 1'b0;
        cmp("ld_wb_valid", 64'(bus.wb_valid), 64'd1);
        cmp("ld_wb_data", bus.wb_data, 64'hBEEF);
        cmp("ld_wb_rw", 64'(bus.wb_reg_write), 64'd1);
        cmp("ld_wb_rd", 64'(bus.wb_rd), 64'd9);

        // Misaligned load, load+store together, misaligned store
        put(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 64'h104, 64'h0);
        tick();
        cmp("mis_wb_valid", 64'(bus.wb_valid), 64'd1);
        cmp("mis_fault", 64'(bus.fault), 64'd1);
        cmp("mis_rw", 64'(bus.wb_reg_write), 64'd0);
        cmp("mis_dm_req", 64'(bus.dm_req), 64'd0);
        put(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 64'h200, 64'h77);
        tick();
        cmp("rw_wb_valid", 64'(bus.wb_valid), 64'd1);
        cmp("rw_fault", 64'(bus.fault), 64'd1);
        cmp("rw_dm_req", 64'(bus.dm_req), 64'd0);
        put(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 64'h101, 64'h99);
        tick();
        idle_in();
        cmp("mst_fault", 64'(bus.fault), 64'd1);
        tick();
        cmp("fault_pulse", 64'(bus.fault), 64'd0);
        cmp("fault_wb_pulse", 64'(bus.wb_valid), 64'd0);

        // Reset during WAIT, then a late response
        put(1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 64'h110, 64'h0);
        tick();
        idle_in();
        bus.dm_gnt = 1'b1;
        tick();
        bus.dm_gnt = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cmp("abort_ready", 64'(bus.ex_ready), 64'd1);
        cmp("abort_req", 64'(bus.dm_req), 64'd0);
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 64'hBAD;
        tick();
        bus.dm_rvalid = 1'b0;
        cmp("abort_wb_valid", 64'(bus.wb_valid), 64'd0);
        put(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 64'h55, 64'h0);
        tick();
        idle_in();
        cmp("post_abort_data", bus.wb_data, 64'h55);
        cmp("post_abort_rd", 64'(bus.wb_rd), 64'd1);

        // Two ALU ops on consecutive edges
        put(1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 64'hA1, 64'h0);
        tick();
        put(1'b1, 1'b0, 1'b0, 1'b0, 5'd21, 64'hA2, 64'h0);
        tick();
        idle_in();
        cmp("alu2_data", bus.wb_data, 64'hA2);
        cmp("alu2_rw", 64'(bus.wb_reg_write), 64'd0);
        tick();

        // Load, ALU op, store with ex_valid held high
        c0 = wb_count;
        put(1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 64'h118, 64'h0);
        tick();
        put(1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 64'h77, 64'h0);
        bus.dm_gnt = 1'b1;
        tick();
        bus.dm_gnt    = 1'b0;
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 64'hCAFE;
        tick();
        bus.dm_rvalid = 1'b0;
        cmp("b2b_ld_data", bus.wb_data, 64'hCAFE);
        cmp("b2b_ld_rd", 64'(bus.wb_rd), 64'd10);
        cmp("b2b_ready", 64'(bus.ex_ready), 64'd1);
        tick();
        put(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 64'h120, 64'h1234);
        cmp("b2b_alu_data", bus.wb_data, 64'h77);
        cmp("b2b_alu_rd", 64'(bus.wb_rd), 64'd11);
        tick();
        idle_in();
        cmp("b2b_st_addr", bus.dm_addr, 64'h120);
        cmp("b2b_st_wdata", bus.dm_wdata, 64'h1234);
        bus.dm_gnt = 1'b1;
        tick();
        bus.dm_gnt = 1'b0;
        cmp("b2b_st_wb", 64'(bus.wb_valid), 64'd1);
        cmp("b2b_st_rw", 64'(bus.wb_reg_write), 64'd0);
        tick();
        tick();
        cmp("b2b_wb_count", 64'(wb_count - c0), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
